// File: rtl/axi_aw_burst_gen.sv
// rtl/axi_aw_burst_gen.sv - AXI write-address burst expander: buffers AW requests, emits one beat per 4-byte transfer
//
// Purpose: accepts AW requests into a DEPTH-entry FIFO and expands each
// request into awlen+1 incrementing 4-byte beats. Consecutive bursts are
// issued without an idle cycle between them.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   awid/awaddr/awlen   AW request fields (awlen = beats-1)
//   awvalid/awready     AW request handshake
//   beat_id/beat_addr   ID and byte address of the current beat
//   beat_last           final beat of the current burst
//   beat_valid/ready    beat handshake
//   fifo_count          AW entries buffered, excluding the burst in progress
module axi_aw_burst_gen #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ID_W-1:0]          awid,
  input  logic [ADDR_W-1:0]        awaddr,
  input  logic [LEN_W-1:0]         awlen,
  input  logic                     awvalid,
  output logic                     awready,
  output logic [ID_W-1:0]          beat_id,
  output logic [ADDR_W-1:0]        beat_addr,
  output logic                     beat_last,
  output logic                     beat_valid,
  input  logic                     beat_ready,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t state, state_next;

  logic [ID_W-1:0]   mem_id   [DEPTH];
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [LEN_W-1:0]  mem_len  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;

  logic [ID_W-1:0]   cur_id;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  remaining;

  logic push, pop, advance, beat_fire;

  // Full is judged on the registered count only, so a pop in the same
  // cycle never lets a push into a full FIFO.
  assign awready   = (fifo_count < CNT_W'(DEPTH)) && !rst;
  assign push      = awvalid && awready;
  assign beat_fire = beat_valid && beat_ready;

  assign beat_valid = (state == BURST);
  assign beat_id    = cur_id;
  assign beat_addr  = cur_addr;
  assign beat_last  = beat_valid && (remaining == '0);

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          pop        = 1'b1;
          state_next = BURST;
        end
      end
      BURST: begin
        if (beat_fire) begin
          if (remaining != '0) begin
            advance = 1'b1;
          end else if (fifo_count != '0) begin
            // Chain straight into the next buffered burst.
            pop = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Storage array carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_id[wr_ptr]   <= awid;
      mem_addr[wr_ptr] <= awaddr;
      mem_len[wr_ptr]  <= awlen;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap by overflow.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_id    <= '0;
      cur_addr  <= '0;
      remaining <= '0;
    end else if (pop) begin
      cur_id    <= mem_id[rd_ptr];
      cur_addr  <= mem_addr[rd_ptr];
      remaining <= mem_len[rd_ptr];
    end else if (advance) begin
      // Align down to the 4-byte beat, then step; wraps at 2^ADDR_W.
      cur_addr  <= (cur_addr & ~ADDR_W'(3)) + ADDR_W'(4);
      remaining <= remaining - LEN_W'(1);
    end
  end

endmodule

// File: tb/tb_axi_aw_burst_gen.sv
// tb/tb_axi_aw_burst_gen.sv - scoreboard bench for axi_aw_burst_gen
module tb_axi_aw_burst_gen;

  logic        clk;
  logic        rst;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid;
  logic        awready;
  logic [3:0]  beat_id;
  logic [31:0] beat_addr;
  logic        beat_last;
  logic        beat_valid;
  logic        beat_ready;
  logic [2:0]  fifo_count;

  axi_aw_burst_gen #(.ID_W(4), .ADDR_W(32), .LEN_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .beat_id(beat_id), .beat_addr(beat_addr), .beat_last(beat_last),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic        last;
  } beat_t;

  beat_t sb[$];
  int tests;
  int fails;

  logic        stalled;
  logic [3:0]  held_id;
  logic [31:0] held_addr;
  logic        held_last;

  // One clock: at the negedge record accepted AWs into the scoreboard,
  // compare any completed beat against its head and check stall stability.
  task automatic cycle();
    beat_t       e;
    beat_t       exp_b;
    logic [31:0] a;
    @(negedge clk);
    if (awvalid && awready && !rst) begin
      a = awaddr;
      for (int i = 0; i <= int'(awlen); i++) begin
        e.id   = awid;
        e.addr = a;
        e.last = (i == int'(awlen));
        sb.push_back(e);
        a = (a & ~32'd3) + 32'd4;
      end
    end
    if (beat_valid) begin
      if (stalled) begin
        tests++;
        if (beat_id !== held_id || beat_addr !== held_addr || beat_last !== held_last) begin
          fails++;
          $display("FAIL stall_hold got id=%h addr=%h last=%b exp id=%h addr=%h last=%b",
                   beat_id, beat_addr, beat_last, held_id, held_addr, held_last);
        end
      end
      if (beat_ready) begin
        stalled = 1'b0;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_beat got id=%h addr=%h last=%b exp none", beat_id, beat_addr, beat_last);
        end else begin
          exp_b = sb.pop_front();
          if (beat_id !== exp_b.id || beat_addr !== exp_b.addr || beat_last !== exp_b.last) begin
            fails++;
            $display("FAIL beat got id=%h addr=%h last=%b exp id=%h addr=%h last=%b",
                     beat_id, beat_addr, beat_last, exp_b.id, exp_b.addr, exp_b.last);
          end
        end
      end else begin
        stalled   = 1'b1;
        held_id   = beat_id;
        held_addr = beat_addr;
        held_last = beat_last;
      end
    end else begin
      stalled = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    int   n;
    logic acc;
    n = 0;
    awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
    do begin
      acc = awready;
      cycle();
      n++;
    end while (!acc && n < 200);
    awvalid = 1'b0;
    tests++;
    if (!acc) begin
      fails++;
      $display("FAIL aw_accept_timeout got awready=0 exp 1 id=%h", id);
    end
  endtask

  task automatic drain(input bit rnd);
    int n;
    n = 0;
    while ((sb.size() != 0 || beat_valid) && n < 2000) begin
      if (rnd) beat_ready = 1'($urandom_range(0, 1));
      cycle();
      n++;
    end
    beat_ready = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    tests++;
    if (sb.size() != 0 || beat_valid) begin
      fails++;
      $display("FAIL drain got pending=%0d valid=%b exp 0 0", sb.size(), beat_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; awvalid = 1'b0; beat_ready = 1'b0;
    cycle(); cycle();
    tests++;
    if (beat_valid !== 1'b0 || beat_last !== 1'b0) begin
      fails++; $display("FAIL reset_valid_last got %b %b exp 0 0", beat_valid, beat_last);
    end
    tests++;
    if (beat_addr !== 32'h0 || beat_id !== 4'h0) begin
      fails++; $display("FAIL reset_addr_id got %h %h exp 0 0", beat_addr, beat_id);
    end
    tests++;
    if (fifo_count !== 3'd0) begin
      fails++; $display("FAIL reset_count got %0d exp 0", fifo_count);
    end
    tests++;
    if (awready !== 1'b0) begin
      fails++; $display("FAIL reset_awready got %b exp 0", awready);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (awready !== 1'b1) begin
      fails++; $display("FAIL release_awready got %b exp 1", awready);
    end
    sb.delete();
    stalled = 1'b0;
  endtask

  task automatic test_single();
    beat_ready = 1'b1;
    awid = 4'd3; awaddr = 32'h100; awlen = 8'd0; awvalid = 1'b1;
    cycle();
    awvalid = 1'b0;
    tests++;
    if (beat_valid !== 1'b0) begin
      fails++; $display("FAIL latency_early got valid=%b exp 0", beat_valid);
    end
    cycle();
    tests++;
    if (beat_valid !== 1'b1 || beat_id !== 4'd3 || beat_addr !== 32'h100 || beat_last !== 1'b1) begin
      fails++;
      $display("FAIL single_beat got v=%b id=%h addr=%h last=%b exp 1 3 00000100 1",
               beat_valid, beat_id, beat_addr, beat_last);
    end
    cycle();
    tests++;
    if (beat_valid !== 1'b0) begin
      fails++; $display("FAIL single_idle got valid=%b exp 0", beat_valid);
    end
    drain(1'b0);
  endtask

  task automatic test_incr();
    beat_ready = 1'b1;
    issue(4'd5, 32'h1002, 8'd3);
    drain(1'b0);
    issue(4'd4, 32'hFFFF_FFFC, 8'd1);
    drain(1'b0);
    issue(4'd6, 32'h0000_2000, 8'd255);
    drain(1'b0);
  endtask

  task automatic test_full();
    int acc;
    acc = 0;
    beat_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      awid = 4'(i); awaddr = 32'h200 + 32'(16 * i); awlen = 8'd0; awvalid = 1'b1;
      if (awready) acc++;
      cycle();
    end
    tests++;
    if (acc != 5) begin
      fails++; $display("FAIL full_accepted got %0d exp 5", acc);
    end
    tests++;
    if (fifo_count !== 3'd4 || awready !== 1'b0) begin
      fails++; $display("FAIL full_state got count=%0d awready=%b exp 4 0", fifo_count, awready);
    end
    cycle(); cycle(); cycle();
    tests++;
    if (awready !== 1'b0) begin
      fails++; $display("FAIL full_hold got awready=%b exp 0", awready);
    end
    beat_ready = 1'b1;
    cycle();
    tests++;
    if (awready !== 1'b1 || fifo_count !== 3'd3) begin
      fails++; $display("FAIL full_free got awready=%b count=%0d exp 1 3", awready, fifo_count);
    end
    cycle();
    awvalid = 1'b0;
    drain(1'b0);
  endtask

  task automatic test_back_to_back();
    beat_ready = 1'b0;
    issue(4'd1, 32'h300, 8'd1);
    issue(4'd2, 32'h400, 8'd1);
    cycle(); cycle();
    tests++;
    if (fifo_count !== 3'd1) begin
      fails++; $display("FAIL b2b_count got %0d exp 1", fifo_count);
    end
    beat_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (beat_valid !== 1'b1 || beat_last !== 1'(k % 2)) begin
        fails++; $display("FAIL b2b_beat%0d got v=%b last=%b exp 1 %0d", k, beat_valid, beat_last, k % 2);
      end
      cycle();
    end
    tests++;
    if (beat_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_end got valid=%b exp 0", beat_valid);
    end
    for (int j = 0; j < 4; j++) begin
      beat_ready = 1'($urandom_range(0, 1));
      issue(4'($urandom_range(0, 15)), $urandom, 8'($urandom_range(0, 5)));
    end
    drain(1'b1);
  endtask

  task automatic test_reset_mid();
    beat_ready = 1'b0;
    issue(4'd7, 32'h800, 8'd7);
    issue(4'd8, 32'h900, 8'd0);
    issue(4'd9, 32'hA00, 8'd0);
    cycle();
    tests++;
    if (fifo_count !== 3'd2) begin
      fails++; $display("FAIL mid_count got %0d exp 2", fifo_count);
    end
    beat_ready = 1'b1;
    cycle();
    beat_ready = 1'b0;
    tests++;
    if (beat_valid !== 1'b1 || beat_addr !== 32'h804) begin
      fails++; $display("FAIL mid_second got v=%b addr=%h exp 1 00000804", beat_valid, beat_addr);
    end
    rst = 1'b1;
    cycle();
    tests++;
    if (beat_valid !== 1'b0 || fifo_count !== 3'd0 || awready !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset got v=%b count=%0d awready=%b exp 0 0 0", beat_valid, fifo_count, awready);
    end
    sb.delete();
    stalled = 1'b0;
    rst = 1'b0;
    beat_ready = 1'b1;
    issue(4'd10, 32'h40, 8'd1);
    drain(1'b0);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0; beat_ready = 1'b0;
    tests = 0; fails = 0; stalled = 1'b0;
    held_id = '0; held_addr = '0; held_last = 1'b0;
    test_reset();
    test_single();
    test_incr();
    test_full();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
